// File: rtl/pc_pkg.sv
// Shared definitions for the program sequencer and the control-unit decoder.
// Holds the pc_op_t operation encoding and a helper that identifies the
// operations that sample the shared data bus.
package pc_pkg;

  localparam int OP_W = 3;

  // Encoding is shared with the control unit decoder; 6 and 7 are unused
  // and behave as OP_HOLD.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_REL  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_t;

  // Operations that take their operand from the shared bus.
  function automatic logic is_bus_op(input pc_op_t op);
    return (op == OP_LOAD) || (op == OP_REL) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program sequencer.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears count only)
//   push, pop : push wdata / drop top entry; ignored when full / empty
//   wdata     : entry to push
//   rdata     : current top entry ('0 when empty)
//   full      : count == STACK_DEPTH
//   empty     : count == 0
module pc_return_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [STACK_DEPTH];

  assign full  = (count == CNT_W'(STACK_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Contents are not reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push && !full && (count == CNT_W'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count == CNT_W'(i + 1)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter for the 8-bit CPU with relative branch and CALL/RET.
// Holds the fetch address and drives it onto the shared tri-state bus.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_databus   : shared bus; carries pc while i_den=0, released otherwise
//   i_den        : active-low bus output enable
//   i_op         : pc_op_t operation for this cycle
//   o_pc         : registered program counter
//   o_overflow   : last INC/REL wrapped the address space
//   o_stk_full   : return stack full
//   o_stk_empty  : return stack empty
//   o_stk_err    : sticky CALL-on-full / RET-on-empty flag
//
// Handshake: there is no valid/ready pair; each cycle carries exactly one
// op, and its result appears on o_pc after the next rising clock edge.
module program_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  inout  wire  [WIDTH-1:0] io_databus,
  input  logic             i_den,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_overflow,
  output logic             o_stk_full,
  output logic             o_stk_empty,
  output logic             o_stk_err
);

  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic             ovf_q, ovf_nxt;
  logic             err_q, err_set;
  logic [WIDTH-1:0] bus_in;
  pc_op_t           op, op_eff;
  logic             conflict;
  logic [WIDTH:0]   inc_sum, rel_sum;
  logic             rel_ovf;
  logic             push, pop;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  // Drive follows i_den combinationally so the bus is released in the
  // same cycle i_den rises.
  assign io_databus = i_den ? {WIDTH{1'bz}} : pc_q;
  assign bus_in     = io_databus;

  assign op = pc_op_t'(i_op);

  // While the sequencer owns the bus it cannot also read an operand from
  // it, so bus-reading ops collapse to HOLD.
  assign conflict = !i_den && is_bus_op(op);
  assign op_eff   = conflict ? OP_HOLD : op;

  assign inc_sum = {1'b0, pc_q} + {{WIDTH{1'b0}}, 1'b1};
  assign rel_sum = {1'b0, pc_q} + {1'b0, bus_in};

  // With the offset read as two's complement, a negative offset underflows
  // when the unsigned add produces no carry, and a non-negative offset
  // overflows when it does.
  assign rel_ovf = bus_in[WIDTH-1] ? !rel_sum[WIDTH] : rel_sum[WIDTH];

  always_comb begin
    pc_nxt  = pc_q;
    ovf_nxt = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (op_eff)
      OP_INC: begin
        pc_nxt  = inc_sum[WIDTH-1:0];
        ovf_nxt = inc_sum[WIDTH];
      end
      OP_LOAD: begin
        pc_nxt  = bus_in;
        ovf_nxt = 1'b0;
      end
      OP_REL: begin
        pc_nxt  = rel_sum[WIDTH-1:0];
        ovf_nxt = rel_ovf;
      end
      OP_CALL: begin
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push    = 1'b1;
          pc_nxt  = bus_in;
          ovf_nxt = 1'b0;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_nxt  = stk_top;
          ovf_nxt = 1'b0;
        end
      end
      default: begin
        pc_nxt  = pc_q;
        ovf_nxt = ovf_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      ovf_q <= ovf_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Return address is pc+1, which is exactly the INC adder output.
  pc_return_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (inc_sum[WIDTH-1:0]),
    .rdata (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign o_pc        = pc_q;
  assign o_overflow  = ovf_q;
  assign o_stk_full  = stk_full;
  assign o_stk_empty = stk_empty;
  assign o_stk_err   = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (WIDTH=8, STACK_DEPTH=4, RESET_VEC=0).
// Each step drives one op and queues the expected
// {pc, overflow, full, empty, stk_err} tuple; the tuple is popped and
// compared one clock later, after the DUT has registered the op.
module tb_program_sequencer;
  import pc_pkg::*;

  localparam int W  = 8;
  localparam int EW = W + 4;

  logic         clk;
  logic         rst;
  logic         den;
  logic [2:0]   op;
  logic         tb_oe;
  logic [W-1:0] tb_val;
  wire  [W-1:0] databus;
  logic [W-1:0] pc;
  logic         ovf, full, empty, err;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign databus = tb_oe ? tb_val : {W{1'bz}};

  program_sequencer #(
    .WIDTH       (W),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .io_databus  (databus),
    .i_den       (den),
    .i_op        (op),
    .o_pc        (pc),
    .o_overflow  (ovf),
    .o_stk_full  (full),
    .o_stk_empty (empty),
    .o_stk_err   (err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [EW-1:0] e(input logic [W-1:0] p, input logic o,
                                      input logic f, input logic m, input logic r);
    return {p, o, f, m, r};
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag);
    logic [EW-1:0] obs;
    logic [EW-1:0] expv;
    obs = {pc, ovf, full, empty, err};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed pc/ovf/full/empty/err=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  // Driver: apply one op for one cycle and check its registered effect.
  task automatic step(input string tag, input logic r, input logic [2:0] o,
                      input logic d, input logic drv, input logic [W-1:0] v,
                      input logic [EW-1:0] expv);
    @(negedge clk);
    rst    = r;
    op     = o;
    den    = d;
    tb_oe  = drv;
    tb_val = v;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    check_out(tag);
    rst   = 1'b0;
    tb_oe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; op = OP_HOLD; den = 1'b0; tb_oe = 1'b0; tb_val = '0;

    // 1: reset, count up, bus drive and release
    step("reset",  1, OP_HOLD, 0, 0, 8'h00, e(8'h00, 0, 0, 1, 0));
    step("inc1",   0, OP_INC,  0, 0, 8'h00, e(8'h01, 0, 0, 1, 0));
    step("inc2",   0, OP_INC,  0, 0, 8'h00, e(8'h02, 0, 0, 1, 0));
    step("inc3",   0, OP_INC,  0, 0, 8'h00, e(8'h03, 0, 0, 1, 0));
    @(negedge clk);
    op = OP_HOLD; den = 1'b0;
    #1 check_val("bus_drive", databus, 8'h03);
    den = 1'b1; tb_oe = 1'b1; tb_val = 8'hA5;
    #1 check_val("bus_release", databus, 8'hA5);
    tb_oe = 1'b0;

    // 2: INC wrap, overflow retained on HOLD, cleared by LOAD
    step("load_ff",   0, OP_LOAD, 1, 1, 8'hFF, e(8'hFF, 0, 0, 1, 0));
    step("inc_wrap",  0, OP_INC,  1, 0, 8'h00, e(8'h00, 1, 0, 1, 0));
    step("hold_ovf",  0, OP_HOLD, 1, 0, 8'h00, e(8'h00, 1, 0, 1, 0));
    step("load_10",   0, OP_LOAD, 1, 1, 8'h10, e(8'h10, 0, 0, 1, 0));

    // 3: relative branches
    step("rel_neg_ok",   0, OP_REL,  1, 1, 8'hF0, e(8'h00, 0, 0, 1, 0));
    step("load_05",      0, OP_LOAD, 1, 1, 8'h05, e(8'h05, 0, 0, 1, 0));
    step("rel_neg_wrap", 0, OP_REL,  1, 1, 8'hF0, e(8'hF5, 1, 0, 1, 0));
    step("load_f0",      0, OP_LOAD, 1, 1, 8'hF0, e(8'hF0, 0, 0, 1, 0));
    step("rel_pos_wrap", 0, OP_REL,  1, 1, 8'h20, e(8'h10, 1, 0, 1, 0));
    step("rel_pos_ok",   0, OP_REL,  1, 1, 8'h05, e(8'h15, 0, 0, 1, 0));
    step("load_10b",     0, OP_LOAD, 1, 1, 8'h10, e(8'h10, 0, 0, 1, 0));

    // 4: nested calls to full, overflow call, unwind
    step("call_20", 0, OP_CALL, 1, 1, 8'h20, e(8'h20, 0, 0, 0, 0));
    step("call_30", 0, OP_CALL, 1, 1, 8'h30, e(8'h30, 0, 0, 0, 0));
    step("call_40", 0, OP_CALL, 1, 1, 8'h40, e(8'h40, 0, 0, 0, 0));
    step("call_50", 0, OP_CALL, 1, 1, 8'h50, e(8'h50, 0, 1, 0, 0));
    step("call_full", 0, OP_CALL, 1, 1, 8'h60, e(8'h50, 0, 1, 0, 1));
    step("ret_41",  0, OP_RET,  1, 0, 8'h00, e(8'h41, 0, 0, 0, 1));
    step("ret_31",  0, OP_RET,  1, 0, 8'h00, e(8'h31, 0, 0, 0, 1));
    step("ret_21",  0, OP_RET,  1, 0, 8'h00, e(8'h21, 0, 0, 0, 1));
    step("ret_11",  0, OP_RET,  1, 0, 8'h00, e(8'h11, 0, 0, 1, 1));

    // 5: RET on empty, sticky error, cleared by reset
    step("reset2",    1, OP_HOLD, 1, 0, 8'h00, e(8'h00, 0, 0, 1, 0));
    step("ret_empty", 0, OP_RET,  1, 0, 8'h00, e(8'h00, 0, 0, 1, 1));
    for (int i = 1; i <= 10; i++) begin
      step("err_sticky", 0, OP_INC, 1, 0, 8'h00, e(W'(i), 0, 0, 1, 1));
    end
    step("reset3",    1, OP_HOLD, 1, 0, 8'h00, e(8'h00, 0, 0, 1, 0));

    // 6: bus conflicts are suppressed, reset beats CALL
    step("inc_pre",       0, OP_INC,  1, 0, 8'h00, e(8'h01, 0, 0, 1, 0));
    step("conflict_load", 0, OP_LOAD, 0, 0, 8'hAA, e(8'h01, 0, 0, 1, 0));
    step("conflict_rel",  0, OP_REL,  0, 0, 8'h00, e(8'h01, 0, 0, 1, 0));
    step("conflict_call", 0, OP_CALL, 0, 0, 8'h00, e(8'h01, 0, 0, 1, 0));
    step("op6_hold",      0, 3'd6,    1, 0, 8'h00, e(8'h01, 0, 0, 1, 0));
    step("call_70",       0, OP_CALL, 1, 1, 8'h70, e(8'h70, 0, 0, 0, 0));
    step("rst_over_call", 1, OP_CALL, 1, 1, 8'h55, e(8'h00, 0, 0, 1, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
